// File: rtl/rr_arbiter4_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
// Imported by the arbiter top and its grant decoder.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_decoder.sv
// 2-to-4 one-hot decoder with enable.
// Output is all zero while enable is low.
module Decoder2_4
    import rr_arbiter4_pkg::*;
(
    input  logic [ID_W-1:0]    a,
    input  logic               enable,
    output logic [NUM_REQ-1:0] b
);

    always_comb begin
        b = '0;
        if (enable) begin
            unique case (a)
                2'd0: b = 4'b0001;
                2'd1: b = 4'b0010;
                2'd2: b = 4'b0100;
                2'd3: b = 4'b1000;
                default: b = '0;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time.
// Grant is decoded from registered state only, so it cannot glitch.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]  last_ptr_q, last_ptr_d;
    logic [ID_W-1:0]  winner;
    logic             hold_last;

    // Scan from the slot after the last winner; the 2-bit index wraps.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        logic            found;
        win   = ptr;
        found = 1'b0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            idx = ptr + ID_W'(o);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner    = rr_pick(req, last_ptr_q);
    assign hold_last = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_ptr_d  = last_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (arb_en && (req != '0)) begin
                    state_d     = GRANT;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    last_ptr_d  = winner;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (!req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                end else if (hold_last) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_ptr_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    Decoder2_4 u_dec (
        .a      (gnt_id_q),
        .enable (gnt_valid_q),
        .b      (gnt)
    );

    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
